// File: rtl/fetch_decode_if.sv
// Fetch/decode bus bundle: core control inputs, instruction-memory port and issued operand bus.
// Latency: none, pure wiring.
// Backpressure: carries stall/redirect/resume from the core; imem data returns one cycle after imem_rd.
interface fetch_decode_if;
  logic        start;
  logic        stall;
  logic        resume;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_rd;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] opcode;
  logic [31:0] oprand1;
  logic [31:0] oprand2;
  logic [31:0] oprand3;
  logic        issue_valid;
  logic [31:0] pc;
  logic        halted;

  // Block side: owns the memory request and the issued operand bus
  modport master (
    input  start, stall, resume, redirect, redirect_pc, imem_rdata,
    output imem_rd, imem_addr, opcode, oprand1, oprand2, oprand3, issue_valid, pc, halted
  );

  // Core/memory side
  modport slave (
    output start, stall, resume, redirect, redirect_pc, imem_rdata,
    input  imem_rd, imem_addr, opcode, oprand1, oprand2, oprand3, issue_valid, pc, halted
  );
endinterface

// File: rtl/fetch_decode.sv
// Instruction fetch + decode: reads one word per instruction, splits it into opcode/operands, holds it on the core bus.
// Latency: FETCH, WAIT, then HOLD_CYCLES of ISSUE (period HOLD_CYCLES+2); FETCH_DECODE_PREFETCH_EN adds a one-entry prefetch buffer for back-to-back issue.
// Backpressure: stall freezes ISSUE (counter, outputs, state); redirect overrides everything outside IDLE; SVC parks in HALT until resume.
module fetch_decode #(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input logic            clk,
  input logic            rst_n,
  fetch_decode_if.master bus
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, ISSUE, HALT} state_t;

  typedef struct packed {
    logic [31:0] opcode;
    logic [31:0] oprand1;
    logic [31:0] oprand2;
    logic [31:0] oprand3;
  } dec_t;

  localparam logic [3:0]  HOLD   = 4'(HOLD_CYCLES);
  localparam logic [11:0] SVC_OP = 12'hEF0;

  // Field split: top 12 bits are the opcode, Rd/Rn nibbles, and either an 8-bit immediate or Rm
  function automatic dec_t decode(input logic [31:0] w);
    dec_t d;
    d.opcode  = {20'b0, w[31:20]};
    d.oprand1 = {28'b0, w[15:12]};
    d.oprand3 = {28'b0, w[19:16]};
    d.oprand2 = w[25] ? {24'b0, w[7:0]} : {28'b0, w[3:0]};
    return d;
  endfunction

  state_t      state;
  logic [31:0] pc_q;       // address of the word being fetched/issued
  logic [3:0]  cnt;        // remaining non-stalled issue cycles
  logic        imem_rd;
  logic [31:0] imem_addr;
  dec_t        dec_q;
  logic [31:0] pc_out;
  logic        issue_valid;
  logic        halted;
  dec_t        dec_w;
  logic        is_svc;

  assign dec_w  = decode(bus.imem_rdata);
  assign is_svc = (dec_q.opcode[11:0] == SVC_OP);

`ifdef FETCH_DECODE_PREFETCH_EN
  logic        pf_req;     // prefetch read issued this cycle
  logic        pf_cap;     // prefetch data on imem_rdata this cycle
  logic        pf_vld;     // pf_word holds the next instruction
  logic [31:0] pf_word;
  dec_t        pf_dec;

  // Returning data is newer than anything buffered, so it wins when both exist
  assign pf_dec = decode(pf_cap ? bus.imem_rdata : pf_word);
`endif

  // Sequencer: fetch, wait for read data, decode, hold the issue, then advance, halt or follow a redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc_q        <= RESET_PC;
      cnt         <= '0;
      imem_rd     <= 1'b0;
      imem_addr   <= '0;
      dec_q       <= '0;
      pc_out      <= '0;
      issue_valid <= 1'b0;
      halted      <= 1'b0;
`ifdef FETCH_DECODE_PREFETCH_EN
      pf_req      <= 1'b0;
      pf_cap      <= 1'b0;
      pf_vld      <= 1'b0;
      pf_word     <= '0;
`endif
    end else begin
      imem_rd <= 1'b0;
`ifdef FETCH_DECODE_PREFETCH_EN
      pf_req <= 1'b0;
      pf_cap <= pf_req;
      // Capture is independent of stall so the returning word is never lost
      if (pf_cap) begin
        pf_word <= bus.imem_rdata;
        pf_vld  <= 1'b1;
      end
`endif
      if (state != IDLE && bus.redirect) begin
        state       <= FETCH;
        pc_q        <= bus.redirect_pc;
        imem_rd     <= 1'b1;
        imem_addr   <= bus.redirect_pc;
        issue_valid <= 1'b0;
        halted      <= 1'b0;
`ifdef FETCH_DECODE_PREFETCH_EN
        pf_cap      <= 1'b0;
        pf_vld      <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              state     <= FETCH;
              imem_rd   <= 1'b1;
              imem_addr <= pc_q;
            end
          end
          FETCH: state <= WAIT;
          WAIT: begin
            dec_q       <= dec_w;
            pc_out      <= pc_q;
            issue_valid <= 1'b1;
            cnt         <= HOLD;
            state       <= ISSUE;
`ifdef FETCH_DECODE_PREFETCH_EN
            pf_vld <= 1'b0;
            if (dec_w.opcode[11:0] != SVC_OP) begin
              imem_rd   <= 1'b1;
              imem_addr <= pc_q + 32'd4;
              pf_req    <= 1'b1;
            end
`endif
          end
          ISSUE: begin
            if (!bus.stall) begin
              if (cnt > 4'd1) begin
                cnt <= cnt - 4'd1;
              end else if (is_svc) begin
                state       <= HALT;
                halted      <= 1'b1;
                issue_valid <= 1'b0;
`ifdef FETCH_DECODE_PREFETCH_EN
                pf_cap      <= 1'b0;
                pf_vld      <= 1'b0;
`endif
              end else begin
                pc_q <= pc_q + 32'd4;
`ifdef FETCH_DECODE_PREFETCH_EN
                if (pf_cap || pf_vld) begin
                  dec_q  <= pf_dec;
                  pc_out <= pc_q + 32'd4;
                  cnt    <= HOLD;
                  pf_vld <= 1'b0;
                  if (pf_dec.opcode[11:0] != SVC_OP) begin
                    imem_rd   <= 1'b1;
                    imem_addr <= pc_q + 32'd8;
                    pf_req    <= 1'b1;
                  end
                end else if (pf_req) begin
                  // Prefetch read still in flight: its data lands during WAIT
                  state       <= WAIT;
                  issue_valid <= 1'b0;
                end else begin
                  state       <= FETCH;
                  imem_rd     <= 1'b1;
                  imem_addr   <= pc_q + 32'd4;
                  issue_valid <= 1'b0;
                end
`else
                state       <= FETCH;
                imem_rd     <= 1'b1;
                imem_addr   <= pc_q + 32'd4;
                issue_valid <= 1'b0;
`endif
              end
            end
          end
          HALT: begin
            if (bus.resume) begin
              halted    <= 1'b0;
              pc_q      <= pc_q + 32'd4;
              state     <= FETCH;
              imem_rd   <= 1'b1;
              imem_addr <= pc_q + 32'd4;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.imem_rd     = imem_rd;
  assign bus.imem_addr   = imem_addr;
  assign bus.opcode      = dec_q.opcode;
  assign bus.oprand1     = dec_q.oprand1;
  assign bus.oprand2     = dec_q.oprand2;
  assign bus.oprand3     = dec_q.oprand3;
  assign bus.pc          = pc_out;
  assign bus.issue_valid = issue_valid;
  assign bus.halted      = halted;

endmodule

// File: doc/fetch_decode.md
FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0, PC loaded at reset.
REQ-002 SHALL have parameter HOLD_CYCLES, default 2, cycles each instruction is presented to the core (legal range 1..15).
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-004 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: start  in  1, begin fetching from current PC when IDLE; stall  in  1, freeze issue; resume  in  1, leave HALT.
REQ-006 SHALL have ports: redirect  in  1, redirect_pc  in  32, branch/flush request and target.
REQ-007 SHALL have ports: imem_rd  out  1, imem_addr  out  32, imem_rdata  in  32, valid the cycle after imem_rd.
REQ-008 SHALL have ports: opcode, oprand1, oprand2, oprand3  out  32 each, core operand bus; issue_valid  out  1; pc  out  32, address of issued word; halted  out  1.

Function
REQ-009 SHALL use FSM states IDLE, FETCH, WAIT, ISSUE, HALT.
REQ-010 IDLE SHALL go to FETCH on start=1; otherwise imem_rd=0 and issue_valid=0.
REQ-011 FETCH SHALL assert imem_rd=1 with imem_addr=PC for one cycle, then go to WAIT.
REQ-012 WAIT SHALL register the decode of imem_rdata into the outputs at the end of the cycle, then go to ISSUE.
REQ-013 Decode SHALL be: opcode = {20'b0, w[31:20]}; oprand1 = w[15:12] (Rd); oprand3 = w[19:16] (Rn); oprand2 = w[7:0] when w[25]=1 (immediate), else w[3:0] (Rm); all zero-extended to 32.
REQ-014 ISSUE SHALL hold issue_valid=1 and stable outputs for HOLD_CYCLES non-stalled cycles, using a 4-bit down-counter.
REQ-015 stall=1 SHALL freeze the counter, outputs and state; issue_valid stays 1 while stalled in ISSUE.
REQ-016 At the end of ISSUE, opcode 12'hEF0 (SVC) SHALL go to HALT; otherwise PC SHALL become PC+4 (32-bit wrap, FFFFFFFC->0) and the FSM SHALL go to FETCH.
REQ-017 HALT SHALL drive halted=1, issue_valid=0 and imem_rd=0; on resume=1 PC SHALL become PC+4 and the FSM SHALL go to FETCH.
REQ-018 In any state but IDLE, redirect=1 SHALL take priority over stall, resume and counter expiry: PC<=redirect_pc, in-flight data discarded, issue_valid=0 next cycle, next state FETCH.
REQ-019 When issue_valid falls, opcode/oprand*/pc SHALL hold their last values.
REQ-020 Without the prefetch feature, the issue period SHALL be HOLD_CYCLES+2 cycles.

Reset
REQ-021 rst_n=0 SHALL immediately, without a clock edge, force state IDLE, PC=RESET_PC, and all outputs to 0 (imem_addr, opcode, oprand1-3, pc, issue_valid, imem_rd, halted).
REQ-022 Reset asserted mid-operation SHALL abandon any fetch or issue; after release the block SHALL wait in IDLE for start.

Configuration
REQ-023 Macro FETCH_DECODE_PREFETCH_EN, when defined, SHALL add a one-entry prefetch buffer.
REQ-024 With the macro defined, the block SHALL issue the fetch of PC+4 in the first ISSUE cycle (not SVC), capture the data, and enter the next ISSUE directly after the current one; for HOLD_CYCLES>=2 instructions issue back-to-back.
REQ-025 With the macro defined, redirect, reset and HALT SHALL discard the buffer, and stall SHALL not block the pending buffer capture.
REQ-026 Without the macro, no buffer SHALL exist and behaviour SHALL be per REQ-020.

Verification
REQ-027 Reset, start, word 0 = E3A01005 -> after FETCH/WAIT, issue_valid=1 for 2 cycles with opcode=0xE3A, oprand1=1, oprand2=5, oprand3=0, pc=0.
REQ-028 Words E1A01002, E0421003, E2822004 at 0/4/8 -> pc 0,4,8 issued with period 4; with FETCH_DECODE_PREFETCH_EN the period is 2 and there is no gap in issue_valid.
REQ-029 stall=1 for 3 cycles mid-ISSUE -> outputs frozen, issue_valid high 5 cycles total, no imem_rd during the stall (macro off).
REQ-030 redirect=1, redirect_pc=0x40 with simultaneous stall=1 during ISSUE -> issue_valid=0 next cycle, then imem_rd with imem_addr=0x40.
REQ-031 Word EF000000 at 0 -> issued, then halted=1 with no imem_rd for 10 cycles; resume -> imem_addr=4.
REQ-032 rst_n=0 mid-ISSUE between clock edges -> all outputs 0 immediately; after release, no imem_rd until start.
